// File: rtl/rp_pkg.sv
// Shared definitions for the reconfigurable-partition AXI4-Lite master.
// Holds the bus widths, the AXI response codes and the controller state
// encoding so the RTL and anything that talks to it agree on them.
package rp_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

endpackage

// File: rtl/rp_axil_master.sv
// rp_axil_master
//   Single-outstanding AXI4-Lite master that carries simple commands into a
//   reconfigurable partition. One command is accepted, issued on AXI, and its
//   result returned on the response port before the next command is taken.
//   If the partition goes inactive (decoupled / held in reset) while a
//   transaction is on the bus, the transaction is abandoned and SLVERR is
//   returned; commands arriving while inactive get SLVERR without touching AXI.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rp_active           partition loaded and out of reset
//   cmd_*               command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*               response out (valid/ready, rdata, resp)
//   m_axi_*             AXI4-Lite master AR/R/AW/W/B channels
//
// Build option
//   RP_AXIL_TIMEOUT_EN  adds a 16-bit watchdog; a transaction still on the
//                       bus TIMEOUT cycles after issue is abandoned with DECERR.
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | waiting for a command, cmd_ready high
// WR_ADDR    | AW and W offered; each drops after its own handshake
// WR_RESP    | bready high, waiting for the write response
// RD_ADDR    | AR offered
// RD_DATA    | rready high, waiting for read data
// RESP       | rsp_valid high, rsp_* held until rsp_ready
module rp_axil_master
    import rp_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rp_active,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [21:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    input  logic [7:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_resp,

    output logic [21:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,

    output logic [21:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
    logic                aw_pend_q,   aw_pend_d;
    logic                w_pend_q,    w_pend_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q,  rsp_resp_d;

    logic axi_busy;
    logic complete;
    logic abort;
    logic issue;
    logic tmo_hit;

    assign axi_busy = (state_q == ST_WR_ADDR) || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

    // Final handshake of a transaction; it takes priority over any abort
    // raised in the same cycle because the slave has already committed it.
    assign complete = ((state_q == ST_WR_RESP) && m_axi_bvalid) ||
                      ((state_q == ST_RD_DATA) && m_axi_rvalid);

    assign abort = axi_busy && (!rp_active || tmo_hit);

    assign issue = (state_q == ST_IDLE) && cmd_valid && rp_active;

`ifdef RP_AXIL_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (issue) begin
            tmo_cnt_d = 16'd0;
        end else if (axi_busy) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic timeout_unused;

    assign tmo_hit        = 1'b0;
    assign timeout_unused = (TIMEOUT != 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (rp_active) begin
                        state_d   = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
                        aw_pend_d = cmd_write;
                        w_pend_d  = cmd_write;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_resp_d  = RESP_SLVERR;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ST_WR_ADDR: begin
                // AW and W complete independently; move on once neither is
                // still pending, which covers both finishing in one cycle.
                aw_pend_d = aw_pend_q && !m_axi_awready;
                w_pend_d  = w_pend_q  && !m_axi_wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d     = ST_RESP;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_d     = ST_RESP;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_rdata_d = m_axi_rdata;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abandoning a transaction mid-flight is only safe because the
        // partition is being decoupled or reset; nothing will answer later.
        if (abort && !complete) begin
            state_d     = ST_RESP;
            aw_pend_d   = 1'b0;
            w_pend_d    = 1'b0;
            rsp_resp_d  = rp_active ? RESP_DECERR : RESP_SLVERR;
            rsp_rdata_d = '0;
        end
    end

    // Outputs
    always_comb begin
        cmd_ready     = (state_q == ST_IDLE);
        rsp_valid     = (state_q == ST_RESP);
        rsp_rdata     = rsp_rdata_q;
        rsp_resp      = rsp_resp_q;

        m_axi_araddr  = addr_q;
        m_axi_arvalid = (state_q == ST_RD_ADDR);
        m_axi_rready  = (state_q == ST_RD_DATA);

        m_axi_awaddr  = addr_q;
        m_axi_awvalid = (state_q == ST_WR_ADDR) && aw_pend_q;
        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = wstrb_q;
        m_axi_wvalid  = (state_q == ST_WR_ADDR) && w_pend_q;
        m_axi_bready  = (state_q == ST_WR_RESP);
    end

endmodule

// File: tb/tb_rp_axil_master.sv
`timescale 1ns/1ps
module tb_rp_axil_master;
    import rp_pkg::*;

`ifdef RP_AXIL_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rp_active = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [21:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic [7:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [21:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [21:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    always #5 clk = ~clk;

    rp_axil_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rp_active(rp_active),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    typedef struct {
        logic        wr;
        logic        act;
        logic [21:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          d_addr;    // slave wait on AW/AR
        int          d_w;       // slave wait on W
        int          d_rsp;     // slave wait on B/R
        logic [63:0] rdata;
        logic [1:0]  sresp;     // slave response code
        int          rsp_dly;   // cycles rsp_ready held low
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic act, input logic [21:0] addr,
                                input logic [63:0] wdata, input logic [7:0] wstrb,
                                input int d_addr, input int d_w, input int d_rsp,
                                input logic [63:0] rdata, input logic [1:0] sresp,
                                input int rsp_dly, input logic [1:0] exp_resp,
                                input logic [63:0] exp_rdata);
        vec_t v;
        v.wr = wr; v.act = act; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.d_addr = d_addr; v.d_w = d_w; v.d_rsp = d_rsp; v.rdata = rdata;
        v.sresp = sresp; v.rsp_dly = rsp_dly; v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Reference: an inactive partition answers SLVERR with no data; otherwise
    // the slave's code comes back, with read data only for reads.
    function automatic vec_t model(input vec_t v);
        v.exp_resp  = v.act ? v.sresp : RESP_SLVERR;
        v.exp_rdata = (v.act && !v.wr) ? v.rdata : 64'h0;
        return v;
    endfunction

    task automatic slave_idle();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0;  m_axi_rvalid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int aw_n = 0, w_n = 0, ar_n = 0;
        int aw_wait = 0, w_wait = 0, ar_wait = 0, rsp_wait = 0;
        bit exp_now, got = 0, lat_bad = 0, data_bad = 0, axi_bad = 0, stab_bad = 0;
        logic [63:0] cap_rdata;
        logic [1:0]  cap_resp;

        @(negedge clk);
        rp_active = v.act;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 22'($urandom);
        cmd_wdata = {$urandom, $urandom};
        cmd_wstrb = 8'($urandom);
        exp_now = !v.act;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (rsp_valid !== exp_now) lat_bad = 1;
            if (rsp_valid) begin
                got = 1;
                slave_idle();
                break;
            end
            if (!v.act && (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid ||
                           m_axi_rready || m_axi_bready)) axi_bad = 1;
            if (m_axi_awvalid && m_axi_awaddr !== v.addr) data_bad = 1;
            if (m_axi_arvalid && m_axi_araddr !== v.addr) data_bad = 1;
            if (m_axi_wvalid && (m_axi_wdata !== v.wdata || m_axi_wstrb !== v.wstrb)) data_bad = 1;

            m_axi_awready = m_axi_awvalid && (aw_wait >= v.d_addr);
            if (m_axi_awvalid) begin if (m_axi_awready) aw_n++; else aw_wait++; end
            m_axi_wready = m_axi_wvalid && (w_wait >= v.d_w);
            if (m_axi_wvalid) begin if (m_axi_wready) w_n++; else w_wait++; end
            m_axi_arready = m_axi_arvalid && (ar_wait >= v.d_addr);
            if (m_axi_arvalid) begin if (m_axi_arready) ar_n++; else ar_wait++; end

            exp_now = 1'b0;
            m_axi_bresp  = v.sresp;
            m_axi_bvalid = m_axi_bready && (rsp_wait >= v.d_rsp);
            if (m_axi_bready) begin if (m_axi_bvalid) exp_now = 1'b1; else rsp_wait++; end
            m_axi_rdata  = v.rdata;
            m_axi_rresp  = v.sresp;
            m_axi_rvalid = m_axi_rready && (rsp_wait >= v.d_rsp);
            if (m_axi_rready) begin if (m_axi_rvalid) exp_now = 1'b1; else rsp_wait++; end
            @(negedge clk);
        end
        slave_idle();
        chk({tag, "_rsp_seen"}, got, 1);

        cap_rdata = rsp_rdata;
        cap_resp  = rsp_resp;
        repeat (v.rsp_dly) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== cap_rdata || rsp_resp !== cap_resp) stab_bad = 1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        chk({tag, "_resp"}, cap_resp, v.exp_resp);
        chk({tag, "_rdata"}, cap_rdata, v.exp_rdata);
        chk({tag, "_aw_hs"}, aw_n, (v.wr && v.act) ? 1 : 0);
        chk({tag, "_w_hs"}, w_n, (v.wr && v.act) ? 1 : 0);
        chk({tag, "_ar_hs"}, ar_n, (!v.wr && v.act) ? 1 : 0);
        chk({tag, "_latency_bad"}, lat_bad, 0);
        chk({tag, "_axi_fields_bad"}, data_bad, 0);
        chk({tag, "_axi_when_inactive"}, axi_bad, 0);
        chk({tag, "_rsp_stable_bad"}, stab_bad, 0);
        chk({tag, "_rsp_dropped"}, rsp_valid, 0);
        chk({tag, "_back_idle"}, cmd_ready, 1);
    endtask

    vec_t tbl[8];
    vec_t rv;
    int   n;
    bit   flag;

    initial begin
        tbl[0] = mk(1, 1, 22'h000100, 64'h1122334455667788, 8'hFF, 0, 2, 1, 64'h0, 2'b00, 0, 2'b00, 64'h0);
        tbl[1] = mk(0, 1, 22'h3FFFF8, 64'h0, 8'h00, 1, 0, 2, 64'hDEADBEEFCAFEF00D, 2'b00, 5, 2'b00, 64'hDEADBEEFCAFEF00D);
        tbl[2] = mk(0, 0, 22'h000010, 64'h0, 8'h00, 0, 0, 0, 64'h5555, 2'b00, 1, 2'b10, 64'h0);
        tbl[3] = mk(1, 0, 22'h000020, 64'hA5A5, 8'h0F, 0, 0, 0, 64'h0, 2'b00, 0, 2'b10, 64'h0);
        tbl[4] = mk(1, 1, 22'h012340, 64'h0123456789ABCDEF, 8'h3C, 0, 0, 0, 64'h0, 2'b10, 0, 2'b10, 64'h0);
        tbl[5] = mk(1, 1, 22'h2AAAA8, 64'hFFFF0000FFFF0000, 8'h81, 3, 0, 3, 64'h0, 2'b11, 2, 2'b11, 64'h0);
        tbl[6] = mk(0, 1, 22'h000008, 64'h0, 8'h00, 0, 0, 0, 64'h0F0F0F0F12345678, 2'b01, 0, 2'b01, 64'h0F0F0F0F12345678);
        tbl[7] = mk(0, 1, 22'h155550, 64'h0, 8'h00, 3, 0, 3, 64'h8000000000000001, 2'b11, 3, 2'b11, 64'h8000000000000001);

        // Reset state
        #1;
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rp_active = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv.wr      = 1'($urandom_range(0, 1));
            rv.act     = ($urandom_range(0, 7) != 0);
            rv.addr    = 22'($urandom);
            rv.wdata   = {$urandom, $urandom};
            rv.wstrb   = 8'($urandom);
            rv.d_addr  = $urandom_range(0, 3);
            rv.d_w     = $urandom_range(0, 3);
            rv.d_rsp   = $urandom_range(0, 3);
            rv.rdata   = {$urandom, $urandom};
            rv.sresp   = 2'($urandom_range(0, 3));
            rv.rsp_dly = $urandom_range(0, 3);
            rv = model(rv);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Partition drops while waiting for read data
        @(negedge clk);
        rp_active = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 22'h000040;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_arvalid", m_axi_arvalid, 1);
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        chk("abort_rready_before", m_axi_rready, 1);
        rp_active = 1'b0;
        @(negedge clk);
        chk("abort_rready_after", m_axi_rready, 0);
        chk("abort_arvalid_after", m_axi_arvalid, 0);
        chk("abort_rsp_valid", rsp_valid, 1);
        chk("abort_rsp_resp", rsp_resp, 2'b10);
        chk("abort_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        rp_active = 1'b1;
        chk("abort_back_idle", cmd_ready, 1);

        // Reset in the middle of a write discards it
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 22'h000200; cmd_wdata = 64'h77; cmd_wstrb = 8'h01;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("midrst_awvalid_before", m_axi_awvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_awvalid", m_axi_awvalid, 0);
        chk("midrst_wvalid", m_axi_wvalid, 0);
        chk("midrst_rsp_resp", rsp_resp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || m_axi_awvalid || m_axi_wvalid) flag = 1;
        end
        chk("midrst_no_rsp", flag, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);

`ifdef RP_AXIL_TIMEOUT_EN
        // arready never comes: abort with DECERR after TMO cycles of arvalid
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 22'h000300;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (!m_axi_arvalid) break;
            n++;
            @(negedge clk);
        end
        chk("tmo_arvalid_cycles", n, 16);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_resp", rsp_resp, 2'b11);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        run_txn(mk(1, 1, 22'h000308, 64'hCAFE, 8'h03, 1, 1, 1, 64'h0, 2'b00, 0, 2'b00, 64'h0), "tmo_b2b");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/rp_axil_master.md
RP_AXIL_MASTER -- requirements
Module: rp_axil_master

Interface
REQ-001 Parameter TIMEOUT, default 1024, is the number of cycles from AXI issue until an abort.
REQ-002 clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rp_active  input  1  high while the reconfigurable partition is loaded and out of reset.
REQ-005 cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  22  byte address.
REQ-008 cmd_wdata/cmd_wstrb  input  64/8  write data and byte strobes.
REQ-009 rsp_valid/rsp_ready  output/input  1/1  response handshake.
REQ-010 rsp_rdata/rsp_resp  output  64/2  read data and AXI response code.
REQ-011 m_axi_araddr[21:0], arvalid (out), arready (in)  AR channel.
REQ-012 m_axi_rdata[63:0], rresp[1:0], rvalid (in), rready (out)  R channel.
REQ-013 m_axi_awaddr[21:0], awvalid (out), awready (in)  AW channel.
REQ-014 m_axi_wdata[63:0], wstrb[7:0], wvalid (out), wready (in)  W channel.
REQ-015 m_axi_bresp[1:0], bvalid (in), bready (out)  B channel.

Function
REQ-016 The FSM SHALL have the states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA and RESP, and SHALL hold exactly one transaction at a time.
REQ-017 cmd_ready SHALL equal (state==IDLE); a command SHALL be accepted when cmd_valid and cmd_ready are high together, and its fields SHALL be registered.
REQ-018 Write accept with rp_active=1 -> WR_ADDR the next cycle, with awvalid and wvalid both high.
- Each valid SHALL drop independently after its own handshake.
- The FSM SHALL enter WR_RESP once both handshakes are done, including both in the same cycle.
REQ-019 WR_RESP: bready SHALL be high; on the bvalid handshake, bresp SHALL be captured into rsp_resp, rsp_rdata SHALL be 0, and the FSM SHALL go to RESP.
REQ-020 Read accept with rp_active=1 -> RD_ADDR with arvalid high; after the arready handshake -> RD_DATA with rready high.
- On the rvalid handshake, rdata and rresp SHALL be captured and the FSM SHALL go to RESP.
REQ-021 Command accept with rp_active=0 -> RESP the next cycle with rsp_resp=2'b10 (SLVERR) and rsp_rdata=0, with no AXI valid asserted.
REQ-022 rp_active falling in any AXI state SHALL abort the transaction.
- All m_axi valid and ready outputs SHALL be low the next cycle.
- The FSM SHALL go to RESP with 2'b10.
- This abort is legal only because the partition is being decoupled or reset.
REQ-023 RESP: rsp_valid SHALL be high and rsp_* SHALL be held stable until the rsp_ready handshake, then the FSM SHALL return to IDLE.
REQ-024 Latency: rsp_valid SHALL rise exactly 1 cycle after the final B or R handshake.
REQ-025 AXI addresses, data and strobes SHALL come from the registered command and SHALL stay stable while the corresponding valid is high.

Reset
REQ-026 On rst_n=0, the state SHALL be IDLE.
- All valid and ready outputs SHALL be 0, except that cmd_ready SHALL follow IDLE after release.
- rsp_rdata SHALL be 0 and rsp_resp SHALL be 0.
- The timeout counter SHALL be 0.
REQ-027 Reset mid-transaction SHALL discard the transaction without producing a response.

Configuration
REQ-028 With RP_AXIL_TIMEOUT_EN defined, a 16-bit counter SHALL clear on AXI issue and increment in every AXI state.
- When it reaches TIMEOUT-1 without completion, the block SHALL abort per REQ-022 but with rsp_resp=2'b11 (DECERR).
- If completion and timeout occur in the same cycle, completion SHALL win.
REQ-029 With RP_AXIL_TIMEOUT_EN undefined, no counter SHALL exist and only rp_active can abort a transaction.

Structure
REQ-030 The state enum, the response codes OKAY/SLVERR/DECERR and the widths 22/64/8 SHALL be placed in the shared package rp_pkg.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Write 0x000100, data 0x1122334455667788, strobe 0xFF; awready 2 cycles before wready; bresp=0 -> one AW and one W handshake, then rsp_resp=0 one cycle after B.
REQ-033 Read 0x3FFFF8 with rdata=0xDEADBEEFCAFEF00D and rresp=0 -> rsp_rdata=0xDEADBEEFCAFEF00D, rsp_resp=0; rsp_ready held low for 5 cycles -> rsp_* stable throughout.
REQ-034 rp_active=0 at command accept -> rsp_resp=2'b10 the next cycle with zero AXI valids.
REQ-035 rp_active dropped while in RD_DATA -> rready=0 the next cycle, then rsp_resp=2'b10.
REQ-036 RP_AXIL_TIMEOUT_EN defined, TIMEOUT=16, arready stuck low -> arvalid drops after 16 cycles and rsp_resp=2'b11; a back-to-back command is then accepted.
